// File: rtl/bit4_register_pkg.sv
// Shared widths and default reset value for the parallel-load register and its bench.
package bit4_register_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    typedef logic [DEFAULT_WIDTH-1:0] data_t;

    localparam data_t DEFAULT_RST_VAL = data_t'(0);

    // Reset value for an arbitrary width, all bits cleared.
    function automatic logic [63:0] rst_val_zero(input int unsigned width);
        logic [63:0] v;
        v = 64'(0);
        for (int unsigned i = 0; i < width && i < 64; i++) begin
            v[i] = 1'b0;
        end
        return v;
    endfunction

endpackage

// File: rtl/bit4_register_cell.sv
// One bit of the parallel-load register: 2:1 load mux feeding an async-reset flop.
// Optional synchronous clear enabled by BIT4_REGISTER_CLR_EN.
module bit4_register_cell
    import bit4_register_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic d,
`ifdef BIT4_REGISTER_CLR_EN
    input  logic clr,
`endif
    output logic q
);

    logic q_q;
    logic q_d;

    // Clear wins over load; hold keeps the stored bit so D is ignored when not loading.
    always_comb begin
        q_d = q_q;
`ifdef BIT4_REGISTER_CLR_EN
        if (clr) begin
            q_d = RST_VAL;
        end else if (load) begin
            q_d = d;
        end
`else
        if (load) begin
            q_d = d;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= RST_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/bit4_register.sv
// WIDTH-bit parallel-load holding register built from one mux+flop cell per bit.
// Defining BIT4_REGISTER_CLR_EN adds a synchronous clear input that overrides load.
module bit4_register
    import bit4_register_pkg::*;
#(
    parameter int unsigned      WIDTH   = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] D,
`ifdef BIT4_REGISTER_CLR_EN
    input  logic             clr,
`endif
    output logic [WIDTH-1:0] q
);

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
        bit4_register_cell #(
            .RST_VAL (RST_VAL[i])
        ) u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (load),
            .d     (D[i]),
`ifdef BIT4_REGISTER_CLR_EN
            .clr   (clr),
`endif
            .q     (q[i])
        );
    end

endmodule

// File: tb/tb_bit4_register.sv
// Self-checking bench for bit4_register: table of per-edge vectors plus reset/clear sequences.
// Clear sequence is exercised only when BIT4_REGISTER_CLR_EN is defined.
module tb_bit4_register;
    import bit4_register_pkg::*;

    localparam int unsigned W = DEFAULT_WIDTH;

    logic         clk;
    logic         rst_n;
    logic         load;
    logic [W-1:0] D;
    logic         clr;
    logic [W-1:0] q;

    int total;
    int bad;

    typedef struct {
        logic         load;
        logic [W-1:0] d;
        logic [W-1:0] exp;
    } vec_t;

    vec_t vecs[13];

    bit4_register #(
        .WIDTH   (W),
        .RST_VAL (DEFAULT_RST_VAL)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .D     (D),
`ifdef BIT4_REGISTER_CLR_EN
        .clr   (clr),
`endif
        .q     (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] exp);
        total++;
        if (q !== exp) begin
            bad++;
            $display("FAIL %s: q=%b expected=%b at t=%0t", name, q, exp, $time);
        end
    endtask

    // Drive on the falling edge, then sample 1 time unit after the next rising edge.
    task automatic step(input logic ld, input logic [W-1:0] d);
        @(negedge clk);
        load = ld;
        D    = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        clr   = 1'b0;

        vecs[0]  = '{1'b0, 4'b0000, 4'b0000};
        vecs[1]  = '{1'b1, 4'b1010, 4'b1010};
        vecs[2]  = '{1'b1, 4'b1100, 4'b1100};
        vecs[3]  = '{1'b0, 4'b0011, 4'b1100};
        vecs[4]  = '{1'b0, 4'b1111, 4'b1100};
        vecs[5]  = '{1'b1, 4'b1001, 4'b1001};
        vecs[6]  = '{1'b1, 4'b1111, 4'b1111};
        vecs[7]  = '{1'b0, 4'b0000, 4'b1111};
        vecs[8]  = '{1'b1, 4'b0101, 4'b0101};
        vecs[9]  = '{1'b1, 4'b0000, 4'b0000};
        vecs[10] = '{1'b1, 4'b1111, 4'b1111};
        vecs[11] = '{1'b0, 4'b1010, 4'b1111};
        vecs[12] = '{1'b1, 4'b0101, 4'b0101};

        // Reset asserted at t=0 takes effect immediately.
        rst_n = 1'b0;
        load  = 1'b0;
        D     = 4'b0000;
        #1;
        check("reset_immediate", 4'b0000);

        // X on load and D during reset across an edge is ignored.
        load = 1'bx;
        D    = 4'b1111;
        @(posedge clk);
        #1;
        check("reset_ignores_x", 4'b0000);
        @(negedge clk);
        load = 1'b0;
        D    = 4'b0000;
        rst_n = 1'b1;
        #1;
        check("release_no_change", 4'b0000);

        for (int i = 0; i < 13; i++) begin
            step(vecs[i].load, vecs[i].d);
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // q = 0101 now; changes of D/load between edges must not disturb q.
        @(negedge clk);
        load = 1'b1;
        D    = 4'b0011;
        #2;
        D    = 4'b1110;
        #1;
        check("stable_between_edges", 4'b0101);
        @(posedge clk);
        #1;
        check("capture_last_d", 4'b1110);

        // Hold with X on D must not leak X into q.
        @(negedge clk);
        load = 1'b0;
        D    = 4'bxxxx;
        @(posedge clk);
        #1;
        check("hold_ignores_x_d", 4'b1110);

        // Mid-cycle reset with a pending load wipes q and blocks the load.
        @(negedge clk);
        load = 1'b1;
        D    = 4'b1111;
        #1;
        rst_n = 1'b0;
        #1;
        check("midcycle_reset", 4'b0000);
        @(posedge clk);
        #1;
        check("reset_blocks_load", 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release_still_zero", 4'b0000);
        @(posedge clk);
        #1;
        check("first_load_after_reset", 4'b1111);

`ifdef BIT4_REGISTER_CLR_EN
        // Clear beats load; next edge with clr low loads normally.
        @(negedge clk);
        clr  = 1'b1;
        load = 1'b1;
        D    = 4'b1010;
        @(posedge clk);
        #1;
        check("clr_over_load", 4'b0000);
        @(negedge clk);
        clr = 1'b0;
        @(posedge clk);
        #1;
        check("load_after_clr", 4'b1010);
        @(negedge clk);
        clr  = 1'b1;
        load = 1'b0;
        @(posedge clk);
        #1;
        check("clr_while_hold", 4'b0000);
        clr = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
